// File: rtl/mem_pkg.sv
// Shared data-memory definitions: funct3 codes, store-RMW FSM states, read-latency bounds.
package mem_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam logic [2:0] ST_B  = 3'b000;
  localparam logic [2:0] ST_H  = 3'b001;
  localparam logic [2:0] ST_W  = 3'b010;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;
  localparam int unsigned LAT_CNT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WT   = 2'd2,
    S_WR   = 2'd3
  } rmw_state_e;

  // Misaligned sh/sw or a funct3 that is not a store.
  function automatic logic store_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      ST_B:    store_bad = 1'b0;
      ST_H:    store_bad = off[0];
      ST_W:    store_bad = |off;
      default: store_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Replaces the addressed byte/half of a read word with store data; sw passes store data through.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  output logic [31:0] merged
);

  always_comb begin
    merged = rdata;
    case (f3)
      ST_B:    merged[{off, 3'b000} +: 8]      = wdata[7:0];
      ST_H:    merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Turns sb/sh/sw into whole-word RAM writes (sub-word stores via read-modify-write)
// and owns the RAM address mux, passing load addresses through when idle.
module store_rmw_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_type,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [31:0]       ld_addr,
  output logic              stall,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  rmw_state_e             state, state_n;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_n;
  logic [ADDR_W-1:0]      addr_q;
  logic [1:0]             off_q;
  logic [31:0]            data_q;
  logic [2:0]             type_q;
  logic                   err_q;
  logic                   accept_c, bad_c, go_c;
  logic [31:0]            merged;
  logic                   unused_bits;

  assign accept_c = (state == S_IDLE) && st_valid;
  assign bad_c    = store_bad(st_type, st_addr[1:0]);
  assign go_c     = accept_c && !bad_c;

  // Next-state: sw writes directly; sb/sh read, wait out RAM latency, then write.
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    case (state)
      S_IDLE: begin
        if (go_c) state_n = (st_type == ST_W) ? S_WR : S_RD;
      end
      S_RD: begin
        if (RD_LAT > 1) begin
          cnt_n   = LAT_CNT_W'(RD_LAT - 2);
          state_n = S_WT;
        end else begin
          state_n = S_WR;
        end
      end
      S_WT: begin
        if (cnt_q == '0) state_n = S_WR;
        else             cnt_n   = cnt_q - LAT_CNT_W'(1);
      end
      S_WR:    state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      off_q    <= '0;
      data_q   <= '0;
      type_q   <= '0;
      err_q    <= 1'b0;
      st_ready <= 1'b1;
      mem_we   <= 1'b0;
      st_done  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt_q    <= cnt_n;
      err_q    <= accept_c && bad_c;
      st_ready <= (state_n == S_IDLE);
      mem_we   <= (state_n == S_WR);
      st_done  <= (state_n == S_WR);
      if (go_c) begin
        addr_q <= st_addr[ADDR_W+1:2];
        off_q  <= st_addr[1:0];
        data_q <= st_data;
        type_q <= st_type;
      end
    end
  end

  lane_merge u_lane_merge (
    .rdata  (mem_rdata),
    .wdata  (data_q),
    .f3     (type_q),
    .off    (off_q),
    .merged (merged)
  );

  assign st_err    = err_q;
  // Stall must cover the accept cycle itself, so it cannot wait for the state register.
  assign stall     = (state != S_IDLE) || go_c;
  assign mem_addr  = (state == S_IDLE) ? ld_addr[ADDR_W+1:2] : addr_q;
  assign mem_wdata = (state == S_WR) ? merged : '0;

  assign unused_bits = ^{st_addr[31:ADDR_W+2], ld_addr[31:ADDR_W+2], ld_addr[1:0]};

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two instances (RD_LAT 1 and 3), each with its own RAM model.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_valid  [2];
  logic        st_ready  [2];
  logic [2:0]  st_type   [2];
  logic [31:0] st_addr   [2];
  logic [31:0] st_data   [2];
  logic [31:0] ld_addr   [2];
  logic        stall     [2];
  logic        st_done   [2];
  logic        st_err    [2];
  logic        mem_we    [2];
  logic [13:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ram   [2][16384];
  logic [31:0] pipe  [2][3];
  logic [31:0] model [2][16384];
  logic        pre_we   [2];
  logic [13:0] pre_addr [2];
  logic [31:0] pre_data [2];

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  [2];
  int exp_we  [2];

  always #5 clk = ~clk;

  store_rmw_unit #(.ADDR_W(14), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid[0]), .st_ready(st_ready[0]),
    .st_type(st_type[0]), .st_addr(st_addr[0]), .st_data(st_data[0]), .ld_addr(ld_addr[0]),
    .stall(stall[0]), .st_done(st_done[0]), .st_err(st_err[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]));

  store_rmw_unit #(.ADDR_W(14), .RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid[1]), .st_ready(st_ready[1]),
    .st_type(st_type[1]), .st_addr(st_addr[1]), .st_data(st_data[1]), .ld_addr(ld_addr[1]),
    .stall(stall[1]), .st_done(st_done[1]), .st_err(st_err[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]));

  // Word RAMs with registered read pipelines of depth 1 and 3.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) ram[k][mem_addr[k]] <= mem_wdata[k];
      if (pre_we[k]) ram[k][pre_addr[k]] <= pre_data[k];
      pipe[k][0] <= ram[k][mem_addr[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) if (mem_we[k]) we_cnt[k] = we_cnt[k] + 1;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Reference store semantics computed byte by byte.
  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [2:0] t,
                                              input logic [1:0] off, input logic [31:0] d);
    logic [7:0] b [4];
    int o;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (t == 3'b010) return d;
    b[o] = d[7:0];
    if (t == 3'b001) b[o+1] = d[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic model_bad(input logic [2:0] t, input logic [1:0] off);
    if (t == 3'b000) return 1'b0;
    if (t == 3'b001) return (off[0] != 1'b0);
    if (t == 3'b010) return (off != 2'b00);
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input int k, input logic [13:0] w, input logic [31:0] v);
    pre_we[k] = 1'b1; pre_addr[k] = w; pre_data[k] = v;
    @(posedge clk); #1;
    pre_we[k] = 1'b0;
    model[k][w] = v;
  endtask

  task automatic idle_cycle(input int k, input logic [31:0] la);
    @(posedge clk); #1;
    st_valid[k] = 1'b0; ld_addr[k] = la;
    #1;
    chk("idle", {mem_we[k], stall[k], st_ready[k], st_done[k], mem_wdata[k], mem_addr[k]},
        {1'b0, 1'b0, 1'b1, 1'b0, 32'h0, la[15:2]});
  endtask

  // One request in the next cycle; checks every cycle until its write (or error pulse).
  task automatic do_store(input int k, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, output logic saw_err, output logic [31:0] wr_w);
    logic bad;
    int lat;
    logic [31:0] la, exp_w;
    bad   = model_bad(t, a[1:0]);
    lat   = (t == 3'b010) ? 1 : 1 + lat_of(k);
    exp_w = model_store(model[k][a[15:2]], t, a[1:0], d);
    la    = $urandom & 32'h0000_fffc;
    wr_w  = 32'h0;
    @(posedge clk); #1;
    st_valid[k] = 1'b1; st_type[k] = t; st_addr[k] = a; st_data[k] = d; ld_addr[k] = la;
    #1;
    chk("accept", {st_ready[k], stall[k], mem_we[k], st_err[k], mem_addr[k]},
        {1'b1, ~bad, 1'b0, 1'b0, la[15:2]});
    @(posedge clk); #1;
    st_valid[k] = 1'b0; st_addr[k] = $urandom; st_data[k] = $urandom; ld_addr[k] = $urandom;
    #1;
    saw_err = st_err[k];
    if (bad) begin
      chk("err_cycle", {st_err[k], stall[k], mem_we[k], st_done[k], st_ready[k]}, 5'b10001);
    end else begin
      for (int c = 1; c <= lat; c++) begin
        if (c > 1) begin @(posedge clk); #2; end
        chk($sformatf("busy_c%0d", c),
            {st_err[k], stall[k], mem_we[k], st_done[k], st_ready[k], mem_addr[k]},
            {1'b0, 1'b1, c == lat, c == lat, 1'b0, a[15:2]});
      end
      wr_w = mem_wdata[k];
      chk("wdata", wr_w, exp_w);
      model[k][a[15:2]] = exp_w;
      exp_we[k]++;
    end
  endtask

  typedef struct {
    int          k;
    logic        pre;
    logic [31:0] pre_val;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic        e;
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      st_valid[k] = 0; st_type[k] = 0; st_addr[k] = 0; st_data[k] = 0; ld_addr[k] = 0;
      pre_we[k] = 0; pre_addr[k] = 0; pre_data[k] = 0; we_cnt[k] = 0; exp_we[k] = 0;
    end
    tbl[0] = '{0, 1'b0, 32'h0,        3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{0, 1'b1, 32'h11223344, 3'b000, 32'h12, 32'h000000AA, 1'b0, 32'h11AA3344};
    tbl[2] = '{0, 1'b1, 32'h11223344, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'hBEEF3344};
    tbl[3] = '{1, 1'b1, 32'h11223344, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'hBEEF3344};
    tbl[4] = '{0, 1'b0, 32'h0,        3'b001, 32'h13, 32'h12345678, 1'b1, 32'h0};
    tbl[5] = '{0, 1'b0, 32'h0,        3'b010, 32'h06, 32'h12345678, 1'b1, 32'h0};
    tbl[6] = '{0, 1'b0, 32'h0,        3'b011, 32'h10, 32'h12345678, 1'b1, 32'h0};
    tbl[7] = '{1, 1'b1, 32'h11223344, 3'b000, 32'h13, 32'hFFFFFF55, 1'b0, 32'h55223344};

    #2 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++)
      chk("reset", {mem_we[k], st_done[k], st_err[k], stall[k], st_ready[k], mem_wdata[k]},
          {5'b00001, 32'h0});
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) preload(k, 14'(i), $urandom);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].pre) preload(tbl[i].k, tbl[i].a[15:2], tbl[i].pre_val);
      do_store(tbl[i].k, tbl[i].t, tbl[i].a, tbl[i].d, e, w);
      chk($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].exp_err));
      if (!tbl[i].exp_err) chk($sformatf("tbl%0d_word", i), w, tbl[i].exp_word);
    end

    idle_cycle(0, 32'h0000_0020);
    idle_cycle(1, 32'h0000_0020);

    // Back-to-back sub-word stores to one word: second read must see the first write.
    for (int k = 0; k < 2; k++) begin
      preload(k, 14'd9, 32'hA0B0C0D0);
      do_store(k, 3'b000, 32'h24, 32'h11, e, w);
      do_store(k, 3'b000, 32'h25, 32'h22, e, w);
      chk("b2b_word", w, 32'hA0B02211);
    end

    // Reset while an sb sits in RD: no write, reset outputs, then normal operation.
    preload(0, 14'd5, 32'hCAFEF00D);
    @(posedge clk); #1;
    st_valid[0] = 1'b1; st_type[0] = 3'b000; st_addr[0] = 32'h14; st_data[0] = 32'h99;
    @(posedge clk); #1;
    st_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst", {mem_we[0], st_done[0], st_err[0], stall[0], st_ready[0], mem_wdata[0]},
        {5'b00001, 32'h0});
    @(posedge clk); #2;
    chk("midrst_hold", {mem_we[0], stall[0], st_ready[0]}, 3'b001);
    @(posedge clk); #1 rst_n = 1'b1;
    do_store(0, 3'b010, 32'h40, 32'h0BADF00D, e, w);
    chk("post_rst_sw", w, 32'h0BADF00D);
    do_store(0, 3'b000, 32'h15, 32'h77, e, w);
    chk("post_rst_word", w, 32'hCAFE770D);

    // Random traffic against the byte-level model.
    for (int i = 0; i < 300; i++) begin
      int k, r;
      logic [2:0]  t;
      logic [31:0] a;
      k = int'($urandom % 2);
      if ($urandom % 3 == 0) idle_cycle(k, $urandom);
      r = int'($urandom % 8);
      t = (r < 6) ? 3'(r % 3) : 3'(r - 3);
      a = ($urandom % 64) | (($urandom % 2 == 1) ? 32'h0010_0000 : 32'h0);
      do_store(k, t, a, $urandom, e, w);
    end

    idle_cycle(0, 32'h0);
    idle_cycle(1, 32'h0);
    for (int k = 0; k < 2; k++) chk("we_count", 64'(we_cnt[k]), 64'(exp_we[k]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
